// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch -- instruction fetch prefetcher with in-order memory interface
//
// Issues word-aligned fetch requests to an instruction memory, tracks the
// outstanding requests with their PCs, and buffers returned instructions in
// a first-word-fall-through FIFO for the decode stage. A redirect (branch,
// return or flush) restarts fetch at a new PC. The FIFO is cleared, and any
// responses still in flight for the old path are counted and silently
// discarded when they return.
//
// Parameters
//   DEPTH     prefetch FIFO entries (power of two, 2..16)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   redirect     restart fetch at redirect_pc (priority over push/pop)
//   redirect_pc  new fetch address, bits [1:0] ignored
//   imem_req     memory request valid
//   imem_addr    memory request address (word aligned)
//   imem_gnt     request accepted when imem_req and imem_gnt are both 1
//   imem_rvalid  read data valid (in request order, latency >= 1)
//   imem_rdata   instruction word
//   if_valid     if_inst / if_pc hold a fetched instruction
//   if_inst      instruction at the FIFO head (NOP when empty)
//   if_pc        PC of if_inst (0 when empty)
//   if_ready     consumer takes the head when if_valid and if_ready are 1
// ---------------------------------------------------------------------------
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        if_ready
);

    // Pointer width and counter width (counters must be able to hold DEPTH)
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    localparam logic [31:0]   NOP_INST = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};

    // Advance a circular pointer; DEPTH is a power of two so it wraps naturally
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return ptr + AW'(1'b1);
    endfunction

    // Fetch address and bookkeeping counters
    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_cnt_r;

    // Prefetch FIFO storage and pointers
    logic [31:0]   fifo_inst_r [DEPTH];
    logic [31:0]   fifo_pc_r   [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;

    // PC queue: one entry per outstanding request, in grant order
    logic [31:0]   pcq_r [DEPTH];
    logic [AW-1:0] pcq_wr_r;
    logic [AW-1:0] pcq_rd_r;

    // Handshake and event decode
    logic          credit_s;
    logic          req_s;
    logic          grant_s;
    logic          rsp_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic [CW-1:0] outstanding_next_s;
    logic [31:0]   head_inst_s;
    logic [31:0]   head_pc_s;
    logic          unused_s;

    // The low address bits of a redirect target are defined as don't-care
    assign unused_s = ^redirect_pc[1:0];

    // A request is only allowed when a FIFO slot is reserved for its response,
    // so the FIFO cannot overflow no matter how long the consumer stalls.
    assign credit_s = (count_r + outstanding_r) < DEPTH_C;
    assign req_s    = rstn & credit_s & ~redirect;
    assign grant_s  = req_s & imem_gnt;

    // A response with nothing outstanding is a protocol violation and ignored
    assign rsp_s    = imem_rvalid & (outstanding_r != CNT_ZERO);
    assign drop_s   = rsp_s & (drop_cnt_r != CNT_ZERO);
    assign push_s   = rsp_s & ~drop_s;

    assign valid_s  = (count_r != CNT_ZERO);
    assign pop_s    = valid_s & if_ready;

    assign outstanding_next_s = outstanding_r + CW'(grant_s) - CW'(rsp_s);

    assign imem_req  = req_s;
    assign imem_addr = fetch_pc_r;
    assign if_valid  = valid_s;
    assign if_inst   = head_inst_s;
    assign if_pc     = head_pc_s;

    // Present the FIFO head, or a NOP at PC 0 while nothing is buffered
    always_comb begin
        head_inst_s = NOP_INST;
        head_pc_s   = 32'h0000_0000;
        if (valid_s) begin
            head_inst_s = fifo_inst_r[rd_ptr_r];
            head_pc_s   = fifo_pc_r[rd_ptr_r];
        end else begin
            head_inst_s = NOP_INST;
            head_pc_s   = 32'h0000_0000;
        end
    end

    // Fetch PC, credit counters, drop counter and all FIFO / PC-queue pointers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_r    <= RESET_PC;
            count_r       <= CNT_ZERO;
            outstanding_r <= CNT_ZERO;
            drop_cnt_r    <= CNT_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            pcq_wr_r      <= PTR_ZERO;
            pcq_rd_r      <= PTR_ZERO;
        end else if (redirect) begin
            // Everything still in flight belongs to the old path: the
            // responses that have not yet returned are all to be dropped.
            fetch_pc_r    <= {redirect_pc[31:2], 2'b00};
            count_r       <= CNT_ZERO;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            outstanding_r <= outstanding_next_s;
            drop_cnt_r    <= outstanding_next_s;
            pcq_wr_r      <= grant_s ? ptr_inc(pcq_wr_r) : pcq_wr_r;
            pcq_rd_r      <= rsp_s ? ptr_inc(pcq_rd_r) : pcq_rd_r;
        end else begin
            fetch_pc_r    <= grant_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
            count_r       <= count_r + CW'(push_s) - CW'(pop_s);
            outstanding_r <= outstanding_next_s;
            drop_cnt_r    <= drop_s ? (drop_cnt_r - CW'(1'b1)) : drop_cnt_r;
            wr_ptr_r      <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
            rd_ptr_r      <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            pcq_wr_r      <= grant_s ? ptr_inc(pcq_wr_r) : pcq_wr_r;
            pcq_rd_r      <= rsp_s ? ptr_inc(pcq_rd_r) : pcq_rd_r;
        end
    end

    // Data storage: PC queue written on grant, FIFO written on a kept response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_inst_r[i] <= NOP_INST;
                fifo_pc_r[i]   <= 32'h0000_0000;
                pcq_r[i]       <= 32'h0000_0000;
            end
        end else begin
            if (grant_s) begin
                pcq_r[pcq_wr_r] <= fetch_pc_r;
            end else begin
                pcq_r[pcq_wr_r] <= pcq_r[pcq_wr_r];
            end
            // A redirect empties the FIFO, so a response in that cycle is not kept
            if (push_s && !redirect) begin
                fifo_inst_r[wr_ptr_r] <= imem_rdata;
                fifo_pc_r[wr_ptr_r]   <= pcq_r[pcq_rd_r];
            end else begin
                fifo_inst_r[wr_ptr_r] <= fifo_inst_r[wr_ptr_r];
                fifo_pc_r[wr_ptr_r]   <= fifo_pc_r[wr_ptr_r];
            end
        end
    end

endmodule
